// File: rtl/shift_serdes.sv
// Full-duplex WIDTH-bit shift engine: loads a word, shifts it out on sout while capturing sin.
// One bit per en strobe (gaps allowed); done pulses one cycle after the last bit, load ignored while busy.
module shift_serdes #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted, dout_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             done_nxt;

    // New sin bit enters at the end opposite to the one driving sout.
    assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        done_nxt  = 1'b0;
        if (state == IDLE) begin
            if (load) begin
                shreg_nxt = din;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
        end else if (en) begin
            shreg_nxt = shifted;
            if (cnt == LAST) begin
                dout_nxt  = shifted;
                done_nxt  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dout  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == SHIFT);
    assign sout = (state == SHIFT) ? ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]) : 1'b0;

endmodule

// File: doc/shift_serdes.md
# shift_serdes

Parametrised, full-duplex serial/parallel shift engine: it loads a WIDTH-bit word, shifts it out on `sout` while capturing `sin`, and presents the received word on `dout` with a one-cycle `done` pulse. It is the framed successor of the fixed 8-bit SIPO/PISO registers. It adds a bit counter, a busy/done handshake, a selectable bit order and a per-bit shift strobe. It sits between a bit-rate strobe generator (UART/SPI-style links) and word-level logic.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 goes out/comes in first; 0 = bit 0 first.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `load`  in  1  start a frame: capture `din`; accepted only in IDLE.
- `din`  in  WIDTH  parallel word to transmit.
- `en`  in  1  bit strobe: one shift per cycle with `en`=1 while in SHIFT.
- `sin`  in  1  serial receive bit, sampled on `en` cycles.
- `sout`  out  1  serial transmit bit.
- `dout`  out  WIDTH  last fully received word, registered.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse after a frame completes.

## Operation
- Internal state:
  - `shreg[WIDTH-1:0]`
  - bit counter `cnt`, width clog2(WIDTH+1)
  - FSM with two states: IDLE and SHIFT.
- IDLE:
  - `load`=1: `shreg`<=`din`, `cnt`<=0, go to SHIFT.
  - `en` is ignored.
- SHIFT:
  - `en`=1, MSB_FIRST=1: `shreg`<={`shreg`[WIDTH-2:0], `sin`}.
  - `en`=1, MSB_FIRST=0: `shreg`<={`sin`, `shreg`[WIDTH-1:1]}.
  - Every `en`=1 cycle also does `cnt`<=`cnt`+1.
  - `en`=0: hold all state.
  - `load` is ignored; no restart, no error.
- Frame end: on the `en` cycle where `cnt`==WIDTH-1:
  - `dout`<= the fully shifted value, including that `sin` bit.
  - `done`<=1, go to IDLE.
  - `cnt` resets to 0.
- `sout` is combinational from state:
  - SHIFT: `shreg`[WIDTH-1] (MSB_FIRST=1) or `shreg`[0] (MSB_FIRST=0).
  - IDLE: 0.
  - The first bit is therefore valid in the cycle after `load` is accepted, before the first `en`.
- `busy` = (state == SHIFT), registered.
- `done` is high exactly one cycle, the first IDLE cycle after the frame.
- Back-to-back frames: `load` during the `done` cycle is accepted. This gives zero idle cycles between frames apart from that one IDLE cycle.
- `dout` changes only at frame end; it holds across later loads and partial frames.

## Timing
- Reset (`rst_n`=0 at a rising edge), outputs: `dout`=0, `busy`=0, `done`=0, `sout`=0.
- Reset, internal state: state=IDLE, `shreg`=0, `cnt`=0.
- Reset overrides `load` and `en` in the same cycle.
- Reset mid-frame aborts the frame. `dout` is cleared, not updated with the partial word, and no `done` pulse is produced.
- Latency:
  - `load` accepted at edge 0 → `busy`=1 and first `sout` bit valid after edge 0.
  - With `en` held high, `done`=1 after edge WIDTH.
  - `dout` is valid in the same cycle as `done`.
- Throughput is one bit per `en` cycle. `en` may have any duty cycle, and gaps are legal anywhere in a frame.
- `sin` is sampled only at `en`=1 edges. Each `sout` bit changes only after an `en` edge.
- `load` and `en` high in the same IDLE cycle: load wins; the `en` is not counted.
- `din` is sampled only at the accepting edge. Later `din` changes do not affect the frame in flight.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `load`=1, `en`=1 → `busy`=0, `done`=0, `dout`=0x00, `sout`=0.
- **MSB-first loopback:** WIDTH=8, MSB_FIRST=1, `sout` tied to `sin`, `din`=0xA5, `load` then 8 `en` cycles.
  - `sout` sequence: 1,0,1,0,0,1,0,1.
  - `done` one cycle after the 8th `en`; `dout`=0xA5.
- **LSB-first with gaps:** MSB_FIRST=0, `din`=0x3C, `en` asserted every 3rd cycle, `sin` fed 1,1,0,0,0,0,1,0.
  - `sout`=0,0,1,1,1,1,0,0; `dout`=0x43.
  - `busy` high throughout the 24-cycle frame.
- **Ignored load and back-to-back frames:**
  - Pulse `load` with `din`=0xFF mid-frame → frame unaffected.
  - `load` `din`=0x01 in the `done` cycle → second frame starts immediately; first `dout` value unaffected until the second `done`.
- **Reset mid-frame:** `rst_n` low after 4 of 8 bits → `busy`=0, `dout`=0x00, no `done`. The next full frame completes normally.
- **WIDTH=16 loopback:** `din`=0xBEEF → `done` after 16 `en` cycles, `dout`=0xBEEF.
